// File: rtl/l1_mem_arbiter_pkg.sv
// Shared LC-3b memory types and the arbiter grant-state encoding.
package l1_mem_arbiter_pkg;
  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_mem_data;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } lc3b_arb_state;

  // bit positions inside the one-hot grant select
  localparam int GNT_I = 0;
  localparam int GNT_D = 1;
endpackage

// File: rtl/l1_mem_arbiter_control.sv
// Grant FSM: round-robin/fixed tie-break, last-grant memory, saturating contention counter.
module l1_mem_arbiter_control #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req,
  input  logic                 d_req,
  input  logic                 l2_resp,
  output logic [1:0]           grant,
  output logic [CNT_WIDTH-1:0] contention_count
);
  import l1_mem_arbiter_pkg::*;

  lc3b_arb_state        state, state_n;
  logic                 last_grant, last_grant_n;  // 0 = I, 1 = D
  logic [CNT_WIDTH-1:0] cnt;
  logic                 tie;

  assign tie = i_req & d_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      if (state == ARB_IDLE && tie && !(&cnt))
        cnt <= cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    case (state)
      ARB_IDLE: begin
        if (tie)        state_n = (ROUND_ROBIN && last_grant) ? ARB_GRANT_I : ARB_GRANT_D;
        else if (i_req) state_n = ARB_GRANT_I;
        else if (d_req) state_n = ARB_GRANT_D;
      end
      ARB_GRANT_I: if (l2_resp) begin
        state_n      = ARB_IDLE;
        last_grant_n = 1'b0;
      end
      ARB_GRANT_D: if (l2_resp) begin
        state_n      = ARB_IDLE;
        last_grant_n = 1'b1;
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Everything is silenced while reset is held, so an abandoned transaction never leaks a resp.
  assign grant[GNT_I]     = !rst && (state == ARB_GRANT_I);
  assign grant[GNT_D]     = !rst && (state == ARB_GRANT_D);
  assign contention_count = rst ? '0 : cnt;
endmodule

// File: rtl/l1_mem_arbiter.sv
// Shares one downstream line port between the L1 I-cache and D-cache; steering muxes live here.
module l1_mem_arbiter import l1_mem_arbiter_pkg::*; #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_read,
  input  logic                 i_write,
  input  lc3b_word             i_address,
  input  lc3b_mem_data         i_wdata,
  output logic                 i_resp,
  output lc3b_mem_data         i_rdata,
  input  logic                 d_read,
  input  logic                 d_write,
  input  lc3b_word             d_address,
  input  lc3b_mem_data         d_wdata,
  output logic                 d_resp,
  output lc3b_mem_data         d_rdata,
  output logic                 l2_read,
  output logic                 l2_write,
  output lc3b_word             l2_address,
  output lc3b_mem_data         l2_wdata,
  input  logic                 l2_resp,
  input  lc3b_mem_data         l2_rdata,
  output logic [CNT_WIDTH-1:0] contention_count
);
  logic [1:0] grant;

  l1_mem_arbiter_control #(
    .ROUND_ROBIN(ROUND_ROBIN),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_ctrl (
    .clk             (clk),
    .rst             (rst),
    .i_req           (i_read | i_write),
    .d_req           (d_read | d_write),
    .l2_resp         (l2_resp),
    .grant           (grant),
    .contention_count(contention_count)
  );

  // Write wins if a requester ever raises both strobes.
  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_resp     = 1'b0;
    i_rdata    = '0;
    d_resp     = 1'b0;
    d_rdata    = '0;
    if (grant[GNT_I]) begin
      l2_read    = i_read & ~i_write;
      l2_write   = i_write;
      l2_address = i_address;
      l2_wdata   = i_wdata;
      i_resp     = l2_resp;
      i_rdata    = l2_rdata;
    end else if (grant[GNT_D]) begin
      l2_read    = d_read & ~d_write;
      l2_write   = d_write;
      l2_address = d_address;
      l2_wdata   = d_wdata;
      d_resp     = l2_resp;
      d_rdata    = l2_rdata;
    end
  end

  a_i_rw: assert property (@(posedge clk) disable iff (rst) !(i_read && i_write));
  a_d_rw: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Two arbiters (round-robin/16-bit count, fixed-priority/4-bit count) against a rule-level model.
module tb_l1_mem_arbiter;
  logic         clk;
  logic [1:0]   rst, i_read, i_write, d_read, d_write, l2_resp;
  logic [1:0]   i_resp, d_resp, l2_read, l2_write;
  logic [15:0]  i_addr [2], d_addr [2], l2_address [2];
  logic [127:0] i_wdata [2], d_wdata [2], l2_rdata [2], l2_wdata [2], i_rdata [2], d_rdata [2];
  logic [15:0]  cnt0;
  logic [3:0]   cnt1;

  int checks = 0, errors = 0;
  // model: owner 0 = none, 1 = I, 2 = D
  int m_own [2], m_last [2], m_cnt [2];
  int cmax [2] = '{65535, 15};
  bit rr   [2] = '{1'b1, 1'b0};
  bit got_i [2], got_d [2], busy [2];
  int lat [2];
  bit rec;
  int ord_dut [2][$], ord_mdl [2][$];
  int req_pct, lat_max, stray_pct, drop_pct, rst_pm;

  l1_mem_arbiter #(.ROUND_ROBIN(1'b1), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst[0]),
    .i_read(i_read[0]), .i_write(i_write[0]), .i_address(i_addr[0]), .i_wdata(i_wdata[0]),
    .i_resp(i_resp[0]), .i_rdata(i_rdata[0]),
    .d_read(d_read[0]), .d_write(d_write[0]), .d_address(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_resp(d_resp[0]), .d_rdata(d_rdata[0]),
    .l2_read(l2_read[0]), .l2_write(l2_write[0]), .l2_address(l2_address[0]), .l2_wdata(l2_wdata[0]),
    .l2_resp(l2_resp[0]), .l2_rdata(l2_rdata[0]), .contention_count(cnt0));

  l1_mem_arbiter #(.ROUND_ROBIN(1'b0), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .rst(rst[1]),
    .i_read(i_read[1]), .i_write(i_write[1]), .i_address(i_addr[1]), .i_wdata(i_wdata[1]),
    .i_resp(i_resp[1]), .i_rdata(i_rdata[1]),
    .d_read(d_read[1]), .d_write(d_write[1]), .d_address(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_resp(d_resp[1]), .d_rdata(d_rdata[1]),
    .l2_read(l2_read[1]), .l2_write(l2_write[1]), .l2_address(l2_address[1]), .l2_wdata(l2_wdata[1]),
    .l2_resp(l2_resp[1]), .l2_rdata(l2_rdata[1]), .contention_count(cnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h exp %h", nm, k, got, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Compare process: expected outputs from the current model owner, then advance the model.
  always @(negedge clk) begin : cmp
    logic er, ew, eir, edr;
    logic [15:0] ea;
    logic [127:0] ewd, eird, edrd, gcnt;
    bit pi, pd;
    for (int k = 0; k < 2; k++) begin
      er = 0; ew = 0; eir = 0; edr = 0; ea = '0; ewd = '0; eird = '0; edrd = '0;
      if (!rst[k] && m_own[k] == 1) begin
        er = i_read[k] & ~i_write[k]; ew = i_write[k]; ea = i_addr[k]; ewd = i_wdata[k];
        eir = l2_resp[k]; eird = l2_rdata[k];
      end else if (!rst[k] && m_own[k] == 2) begin
        er = d_read[k] & ~d_write[k]; ew = d_write[k]; ea = d_addr[k]; ewd = d_wdata[k];
        edr = l2_resp[k]; edrd = l2_rdata[k];
      end
      gcnt = (k == 0) ? 128'(cnt0) : 128'(cnt1);
      chk("l2_read", k, 128'(l2_read[k]), 128'(er));
      chk("l2_write", k, 128'(l2_write[k]), 128'(ew));
      chk("l2_address", k, 128'(l2_address[k]), 128'(ea));
      chk("l2_wdata", k, l2_wdata[k], ewd);
      chk("i_resp", k, 128'(i_resp[k]), 128'(eir));
      chk("i_rdata", k, i_rdata[k], eird);
      chk("d_resp", k, 128'(d_resp[k]), 128'(edr));
      chk("d_rdata", k, d_rdata[k], edrd);
      chk("contention_count", k, gcnt, rst[k] ? 128'd0 : 128'(m_cnt[k]));
      if (eir) got_i[k] = 1;
      if (edr) got_d[k] = 1;
      if (rec && ord_dut[k].size() < 4) begin
        if (i_resp[k]) ord_dut[k].push_back(1);
        if (d_resp[k]) ord_dut[k].push_back(2);
        if (eir) ord_mdl[k].push_back(1);
        if (edr) ord_mdl[k].push_back(2);
      end
      pi = i_read[k] | i_write[k];
      pd = d_read[k] | d_write[k];
      if (rst[k]) begin
        m_own[k] = 0; m_last[k] = 0; m_cnt[k] = 0;
      end else if (m_own[k] == 0) begin
        if (pi && pd) begin
          if (m_cnt[k] < cmax[k]) m_cnt[k]++;
          m_own[k] = (rr[k] && m_last[k] == 1) ? 1 : 2;
        end else if (pi) m_own[k] = 1;
        else if (pd) m_own[k] = 2;
      end else if (l2_resp[k]) begin
        m_last[k] = m_own[k] - 1;
        m_own[k] = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic auto_step();
    for (int k = 0; k < 2; k++) begin
      if (got_i[k]) begin
        i_read[k] = 0; i_write[k] = 0; got_i[k] = 0;
      end else if (!(i_read[k] | i_write[k]) && $urandom_range(99) < req_pct) begin
        if ($urandom_range(1) == 1) i_write[k] = 1; else i_read[k] = 1;
        i_addr[k] = 16'($urandom); i_wdata[k] = r128();
      end else if (m_own[k] == 1 && $urandom_range(99) < drop_pct) begin
        i_read[k] = 0; i_write[k] = 0;
      end
      if (got_d[k]) begin
        d_read[k] = 0; d_write[k] = 0; got_d[k] = 0;
      end else if (!(d_read[k] | d_write[k]) && $urandom_range(99) < req_pct) begin
        if ($urandom_range(1) == 1) d_write[k] = 1; else d_read[k] = 1;
        d_addr[k] = 16'($urandom); d_wdata[k] = r128();
      end else if (m_own[k] == 2 && $urandom_range(99) < drop_pct) begin
        d_read[k] = 0; d_write[k] = 0;
      end
      l2_rdata[k] = r128();
      if (m_own[k] == 0) begin
        busy[k] = 0;
        l2_resp[k] = ($urandom_range(99) < stray_pct);
      end else begin
        if (!busy[k]) begin busy[k] = 1; lat[k] = $urandom_range(lat_max); end
        if (lat[k] == 0) begin l2_resp[k] = 1; busy[k] = 0; end
        else begin l2_resp[k] = 0; lat[k]--; end
      end
      rst[k] = ($urandom_range(999) < rst_pm);
    end
  endtask

  initial begin
    rst = 2'b11; i_read = 0; i_write = 0; d_read = 0; d_write = 0; l2_resp = 0; rec = 0;
    for (int k = 0; k < 2; k++) begin
      i_addr[k] = '0; d_addr[k] = '0; i_wdata[k] = '0; d_wdata[k] = '0; l2_rdata[k] = '0;
    end
    cyc(); cyc(); #1;
    chk("rst_l2_read", 0, 128'(l2_read[0]), 128'd0);
    chk("rst_cnt", 0, 128'(cnt0), 128'd0);

    // lone I read
    cyc(); rst = 2'b00; i_read[0] = 1; i_addr[0] = 16'h1230; #1;
    chk("t1_idle_l2_read", 0, 128'(l2_read[0]), 128'd0);
    cyc(); #1;
    chk("t1_l2_read", 0, 128'(l2_read[0]), 128'd1);
    chk("t1_l2_address", 0, 128'(l2_address[0]), 128'h1230);
    cyc(); cyc(); l2_resp[0] = 1; l2_rdata[0] = {16{8'hA5}}; #1;
    chk("t1_i_resp", 0, 128'(i_resp[0]), 128'd1);
    chk("t1_i_rdata", 0, i_rdata[0], {16{8'hA5}});
    chk("t1_d_resp", 0, 128'(d_resp[0]), 128'd0);
    cyc(); i_read[0] = 0; l2_resp[0] = 0; #1;
    chk("t1_dead_l2_read", 0, 128'(l2_read[0]), 128'd0);
    chk("t1_dead_i_resp", 0, 128'(i_resp[0]), 128'd0);

    // simultaneous request right after reset
    cyc(); rst[0] = 1;
    cyc(); rst[0] = 0; i_read[0] = 1; i_addr[0] = 16'h2222;
    d_write[0] = 1; d_addr[0] = 16'h4000; d_wdata[0] = r128(); #1;
    cyc(); #1;
    chk("t2_l2_write", 0, 128'(l2_write[0]), 128'd1);
    chk("t2_l2_read", 0, 128'(l2_read[0]), 128'd0);
    chk("t2_l2_address", 0, 128'(l2_address[0]), 128'h4000);
    chk("t2_l2_wdata", 0, l2_wdata[0], d_wdata[0]);
    cyc(); l2_resp[0] = 1; #1;
    chk("t2_d_resp", 0, 128'(d_resp[0]), 128'd1);
    chk("t2_i_resp", 0, 128'(i_resp[0]), 128'd0);
    cyc(); d_write[0] = 0; l2_resp[0] = 0; #1;
    chk("t2_dead_l2_read", 0, 128'(l2_read[0]), 128'd0);
    chk("t2_cnt", 0, 128'(cnt0), 128'd1);
    cyc(); #1;
    chk("t2_i_l2_read", 0, 128'(l2_read[0]), 128'd1);
    chk("t2_i_l2_address", 0, 128'(l2_address[0]), 128'h2222);
    cyc(); l2_resp[0] = 1;
    cyc(); i_read[0] = 0; l2_resp[0] = 0;

    // D drops its request while granted; I arrives meanwhile
    cyc(); d_read[0] = 1; d_addr[0] = 16'h5550; #1;
    cyc(); #1;
    chk("t3_l2_read", 0, 128'(l2_read[0]), 128'd1);
    cyc(); d_read[0] = 0; i_read[0] = 1; i_addr[0] = 16'h6660; #1;
    chk("t3_drop_l2_read", 0, 128'(l2_read[0]), 128'd0);
    chk("t3_drop_addr", 0, 128'(l2_address[0]), 128'h5550);
    cyc(); l2_resp[0] = 1; #1;
    chk("t3_d_resp", 0, 128'(d_resp[0]), 128'd1);
    chk("t3_i_resp", 0, 128'(i_resp[0]), 128'd0);
    cyc(); l2_resp[0] = 0; #1;
    chk("t3_dead_l2_read", 0, 128'(l2_read[0]), 128'd0);
    cyc(); #1;
    chk("t3_i_addr", 0, 128'(l2_address[0]), 128'h6660);
    cyc(); l2_resp[0] = 1;
    cyc(); i_read[0] = 0; l2_resp[0] = 0;

    // reset in the middle of an I transaction
    cyc(); i_read[0] = 1; i_addr[0] = 16'h7770;
    cyc(); #1;
    chk("t4_l2_read", 0, 128'(l2_read[0]), 128'd1);
    cyc(); rst[0] = 1; l2_resp[0] = 1; #1;
    chk("t4_rst_i_resp", 0, 128'(i_resp[0]), 128'd0);
    chk("t4_rst_l2_read", 0, 128'(l2_read[0]), 128'd0);
    cyc(); rst[0] = 0; i_read[0] = 0; l2_resp[0] = 0; #1;
    chk("t4_after_l2_read", 0, 128'(l2_read[0]), 128'd0);
    chk("t4_after_cnt", 0, 128'(cnt0), 128'd0);

    // saturation and fixed priority on dut1: both always pending, l2 answers at once
    cyc(); rst[1] = 1;
    cyc(); rst[1] = 0; i_read[1] = 1; d_read[1] = 1; l2_resp[1] = 1;
    for (int c = 1; c <= 40; c++) begin
      cyc(); #1;
      if (c == 3) begin
        chk("t5_fixed_d_resp", 1, 128'(d_resp[1]), 128'd1);
        chk("t5_fixed_i_resp", 1, 128'(i_resp[1]), 128'd0);
      end
      if (c == 10) chk("t5_cnt_mid", 1, 128'(cnt1), 128'd5);
    end
    chk("t5_cnt_sat", 1, 128'(cnt1), 128'hF);
    i_read[1] = 0; d_read[1] = 0; l2_resp[1] = 0;

    // back-to-back ties on both arbiters
    cyc(); rst = 2'b11;
    cyc(); rst = 2'b00;
    got_i = '{0, 0}; got_d = '{0, 0}; busy = '{0, 0};
    req_pct = 100; lat_max = 2; stray_pct = 0; drop_pct = 0; rst_pm = 0; rec = 1;
    for (int c = 0; c < 200 && (ord_dut[0].size() < 4 || ord_dut[1].size() < 4); c++) begin
      cyc(); auto_step();
    end
    @(negedge clk); rec = 0;
    for (int k = 0; k < 2; k++) begin
      chk("b2b_count", k, 128'(ord_dut[k].size()), 128'd4);
      chk("b2b_model_count", k, 128'(ord_mdl[k].size()), 128'd4);
      for (int j = 0; j < ord_dut[k].size() && j < 4; j++)
        chk("b2b_order", k, 128'(ord_dut[k][j]), (j % 2 == 0) ? 128'd2 : 128'd1);
      for (int j = 0; j < ord_mdl[k].size() && j < 4; j++)
        chk("b2b_model_order", k, 128'(ord_mdl[k][j]), (j % 2 == 0) ? 128'd2 : 128'd1);
    end

    // randomized traffic with stray responses, drops and occasional resets
    req_pct = 40; lat_max = 4; stray_pct = 10; drop_pct = 5; rst_pm = 5;
    for (int c = 0; c < 3000; c++) begin
      cyc(); auto_step();
    end
    cyc(); rst = 2'b11; i_read = 0; i_write = 0; d_read = 0; d_write = 0; l2_resp = 0;
    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l1_mem_arbiter.md
Name: l1_mem_arbiter

Overview:
- Two-requester arbiter that shares one physical-memory port between the L1 instruction cache and the L1 data cache.
- Each cache drives its usual line-granular pmem_* interface into this block; the block serialises the two streams onto a single downstream line interface (L2 or physical memory).
- It owns the grant state machine, round-robin fairness, response routing and a saturating contention counter.

Parameters:
- ROUND_ROBIN, 1, 1 = alternate on simultaneous requests; 0 = fixed priority to the D-cache.
- CNT_WIDTH, 16, width of the contention counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- i_read  in  1  I-cache line read request
- i_write  in  1  I-cache line write request
- i_address  in  16 (lc3b_word)  I-cache line address
- i_wdata  in  128 (lc3b_mem_data)  I-cache write line
- i_resp  out  1  I-cache transaction complete
- i_rdata  out  128  I-cache read line
- d_read, d_write, d_address, d_wdata, d_resp, d_rdata  same as the i_ ports, for the D-cache
- l2_read  out  1  downstream read strobe
- l2_write  out  1  downstream write strobe
- l2_address  out  16  downstream line address
- l2_wdata  out  128  downstream write line
- l2_resp  in  1  downstream complete
- l2_rdata  in  128  downstream read line
- contention_count  out  CNT_WIDTH  cycles spent in IDLE with both requesters pending, saturating

Behaviour:
- States: IDLE, GRANT_I, GRANT_D. A last_grant register (0 = I, 1 = D) records the most recent grant.
- Reset:
  - state <= IDLE, last_grant <= 0 (so the D-cache wins the first tie), contention_count <= 0.
  - During and after reset, all outputs are 0 until a grant is issued.
  - Reset in the middle of a transaction abandons it. No i_resp or d_resp is generated for it, and l2_read and l2_write drop in the same cycle the state returns to IDLE.
- IDLE:
  - Outputs to l2 are 0; i_resp = d_resp = 0.
  - A request is pending when read or write is high.
  - Only I pending -> GRANT_I. Only D pending -> GRANT_D.
  - Both pending with ROUND_ROBIN=1: grant the requester that is not last_grant.
  - Both pending with ROUND_ROBIN=0: always GRANT_D.
  - Both pending: contention_count increments by 1 and holds at all-ones.
- GRANT_x:
  - l2_read, l2_write, l2_address and l2_wdata combinationally mirror requester x.
  - x_rdata = l2_rdata. x_resp = l2_resp.
  - The other requester's resp is 0 and its rdata is 0.
  - On l2_resp: last_grant <= x, next state IDLE.
  - Stay in GRANT_x until l2_resp, even if requester x drops its request. The downstream transaction is already committed.
- Latency:
  - Request seen in IDLE at cycle N -> l2 strobe first asserted at N+1.
  - l2_resp at cycle M is delivered to the requester in cycle M, with zero added latency.
  - The state is IDLE at M+1. This mandatory dead cycle lets the requester deassert, so a stale request cannot be re-granted.
  - The earliest next grant is at M+2.
- Requester protocol:
  - Signals are held stable from assertion until resp.
  - Read and write must never be high together on one requester. This is checked by an assertion in simulation; in RTL, write has precedence.
- An l2_resp that arrives in IDLE is ignored and no resp is routed.
- A requester waiting while the other is served receives no resp and is not dropped. It is granted on the next IDLE evaluation.

Decomposition:
- Add typedef enum lc3b_arb_state {ARB_IDLE, ARB_GRANT_I, ARB_GRANT_D} to lc3b_types.
- Reuse lc3b_word and lc3b_mem_data from lc3b_types.
- Natural split:
  - arbiter_control: FSM, last_grant, contention counter; emits a 2-bit grant select.
  - The top-level module holds the combinational steering muxes.

Test Plan:
- Lone I read:
  - Stimulus: i_read=1, i_address=16'h1230, l2_resp after 3 cycles with l2_rdata=128'hA5...A5.
  - Required: l2_read high from cycle 1, i_resp=1 with i_rdata=A5..A5 in the same cycle, d_resp=0, IDLE the next cycle.
- Simultaneous after reset (ROUND_ROBIN=1):
  - Stimulus: i_read and d_write (d_address=16'h4000) both asserted and held until each gets its resp.
  - Required: D served first, with l2_write=1 and l2_address=16'h4000. I is granted 2 cycles after d_resp. contention_count=1.
- Back-to-back ties:
  - Stimulus: both requesters re-request immediately after each resp, for 4 transactions.
  - Required (ROUND_ROBIN=1): grant order D, I, D, I.
  - Required (ROUND_ROBIN=0): D wins every tie while D is pending.
- Requester drops mid-transaction:
  - Stimulus: d_read is deasserted while in GRANT_D.
  - Required: l2_read mirrors the requester and falls, state stays GRANT_D until l2_resp, and d_resp pulses on l2_resp.
- Reset mid-transaction:
  - Stimulus: rst=1 during GRANT_I.
  - Required: next cycle state IDLE, l2_read=0, i_resp never asserted, contention_count=0.
- Saturation (CNT_WIDTH=4):
  - Stimulus: 20 contended IDLE cycles.
  - Required: contention_count stops at 4'hF.
